// File: rtl/life_pkg.sv
// Shared types and helpers for the Game-of-Life engine.
// Provides the FSM state enum and the flat cell index function.
package life_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        HALT = 2'd3
    } life_state_t;

    // Cell (r,c) lives at bit r*cols+c of a flattened grid.
    function automatic int cell_idx(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/life_next.sv
// Combinational B3/S23 next-generation logic for a ROWS x COLS grid.
// Ports: grid_in (current cells), wrap (1 = toroidal edges), grid_out
// (next generation), eq (grid_out == grid_in), zero (grid_out all dead).
module life_next
    import life_pkg::*;
#(
    parameter int ROWS = 16,
    parameter int COLS = 16
) (
    input  logic [ROWS*COLS-1:0] grid_in,
    input  logic                 wrap,
    output logic [ROWS*COLS-1:0] grid_out,
    output logic                 eq,
    output logic                 zero
);

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [8:0] nb;
            logic [3:0] cnt;

            // Neighbour k covers offsets (k/3-1, k%3-1); k==4 is the cell itself.
            for (genvar k = 0; k < 9; k++) begin : g_nb
                localparam int RR = r + k / 3 - 1;
                localparam int CC = c + k % 3 - 1;
                localparam int RW = (RR + ROWS) % ROWS;
                localparam int CW = (CC + COLS) % COLS;
                localparam bit INSIDE = (RR >= 0) && (RR < ROWS) &&
                                        (CC >= 0) && (CC < COLS);
                if (k == 4) begin : g_self
                    assign nb[k] = 1'b0;
                end else if (INSIDE) begin : g_in
                    assign nb[k] = grid_in[cell_idx(RW, CW, COLS)];
                end else begin : g_edge
                    // Off-grid neighbour only counts when the grid wraps.
                    assign nb[k] = grid_in[cell_idx(RW, CW, COLS)] & wrap;
                end
            end

            always_comb begin
                cnt = '0;
                for (int i = 0; i < 9; i++) begin
                    cnt = cnt + {3'b000, nb[i]};
                end
            end

            assign grid_out[cell_idx(r, c, COLS)] =
                (cnt == 4'd3) |
                ((cnt == 4'd2) & grid_in[cell_idx(r, c, COLS)]);
        end
    end

    assign eq   = (grid_out == grid_in);
    assign zero = ~|grid_out;

endmodule

// File: rtl/life_engine.sv
// Game-of-Life generation engine: grid register, generation counter,
// halt-cause flags and the IDLE/RUN/STEP/HALT control FSM.
// Inputs: clk, reset (async), clear, load, seed, start, step, stop, wrap,
// max_gen. Outputs: grid, gen_count, running, done, stable, extinct.
module life_engine
    import life_pkg::*;
#(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 load,
    input  logic [ROWS*COLS-1:0] seed,
    input  logic                 start,
    input  logic                 step,
    input  logic                 stop,
    input  logic                 wrap,
    input  logic [CNT_W-1:0]     max_gen,
    output logic [ROWS*COLS-1:0] grid,
    output logic [CNT_W-1:0]     gen_count,
    output logic                 running,
    output logic                 done,
    output logic                 stable,
    output logic                 extinct
);

    localparam int N = ROWS * COLS;

    life_state_t state_q, state_d;

    logic [N-1:0]     grid_q, grid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             stable_q, stable_d;
    logic             extinct_q, extinct_d;

    logic [N-1:0]     nxt;
    logic             nxt_eq;
    logic             nxt_zero;
    logic [CNT_W:0]   cnt_p1;
    logic [CNT_W-1:0] cnt_inc;
    logic             limit_hit;
    logic             do_upd;

    life_next #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_next (
        .grid_in  (grid_q),
        .wrap     (wrap),
        .grid_out (nxt),
        .eq       (nxt_eq),
        .zero     (nxt_zero)
    );

    // Counter saturates at all-ones; the carry-out marks the wrap point.
    assign cnt_p1  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign cnt_inc = cnt_p1[CNT_W] ? cnt_q : cnt_p1[CNT_W-1:0];

    // Once gen_count >= max_gen the equality can never hold again, so a
    // start issued past the limit naturally runs unbounded.
    assign limit_hit = (max_gen != '0) && (cnt_p1 == {1'b0, max_gen});

    always_comb begin
        state_d   = state_q;
        grid_d    = grid_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        stable_d  = stable_q;
        extinct_d = extinct_q;
        do_upd    = 1'b0;

        if (clear) begin
            state_d   = IDLE;
            grid_d    = '0;
            cnt_d     = '0;
            done_d    = 1'b0;
            stable_d  = 1'b0;
            extinct_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, HALT: begin
                    if (load) begin
                        state_d   = IDLE;
                        grid_d    = seed;
                        cnt_d     = '0;
                        done_d    = 1'b0;
                        stable_d  = 1'b0;
                        extinct_d = 1'b0;
                    end else if (start) begin
                        state_d   = RUN;
                        done_d    = 1'b0;
                        stable_d  = 1'b0;
                        extinct_d = 1'b0;
                    end else if (step) begin
                        state_d   = STEP;
                        done_d    = 1'b0;
                        stable_d  = 1'b0;
                        extinct_d = 1'b0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_d = HALT;
                    end else begin
                        do_upd = 1'b1;
                    end
                end
                STEP: begin
                    do_upd  = 1'b1;
                    state_d = HALT;
                end
                default: state_d = IDLE;
            endcase

            if (do_upd) begin
                grid_d    = nxt;
                cnt_d     = cnt_inc;
                stable_d  = stable_q | nxt_eq;
                extinct_d = extinct_q | nxt_zero;
                done_d    = done_q | limit_hit;
                // Halt cause lands on the same edge as the update it flags.
                if (stable_d | extinct_d | done_d) begin
                    state_d = HALT;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grid_q    <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            stable_q  <= 1'b0;
            extinct_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grid_q    <= grid_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            stable_q  <= stable_d;
            extinct_q <= extinct_d;
        end
    end

    assign grid      = grid_q;
    assign gen_count = cnt_q;
    assign running   = (state_q == RUN);
    assign done      = done_q;
    assign stable    = stable_q;
    assign extinct   = extinct_q;

endmodule

// File: tb/tb_life_engine.sv
// Self-checking bench for life_engine: directed scenarios plus random
// control/seed traffic compared against a behavioural Life model.
module tb_life_engine;

    localparam int ROWS  = 16;
    localparam int COLS  = 16;
    localparam int CNT_W = 16;
    localparam int N     = ROWS * COLS;

    logic             clk = 1'b0;
    logic             reset;
    logic             clear;
    logic             load;
    logic [N-1:0]     seed;
    logic             start;
    logic             step;
    logic             stop;
    logic             wrap;
    logic [CNT_W-1:0] max_gen;
    logic [N-1:0]     grid;
    logic [CNT_W-1:0] gen_count;
    logic             running;
    logic             done;
    logic             stable;
    logic             extinct;

    int errors = 0;
    int checks = 0;

    // Behavioural model: plain grid, integer generation, run/step intent.
    logic [N-1:0] m_grid;
    int           m_gen;
    bit           m_run;
    bit           m_pend;
    bit           m_done;
    bit           m_stable;
    bit           m_extinct;

    logic [N-1:0] vblink, hblink, block, cell00, glider, blk2;

    life_engine #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .load      (load),
        .seed      (seed),
        .start     (start),
        .step      (step),
        .stop      (stop),
        .wrap      (wrap),
        .max_gen   (max_gen),
        .grid      (grid),
        .gen_count (gen_count),
        .running   (running),
        .done      (done),
        .stable    (stable),
        .extinct   (extinct)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] obs,
                         input logic [N-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] put(input logic [N-1:0] g,
                                          input int r, input int c);
        logic [N-1:0] o;
        o = g;
        o[r*COLS+c] = 1'b1;
        return o;
    endfunction

    function automatic logic [N-1:0] life(input logic [N-1:0] g, input bit w);
        logic [N-1:0] o;
        o = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr;
                        int cc;
                        rr = r + dr;
                        cc = c + dc;
                        if (w) begin
                            rr = (rr + ROWS) % ROWS;
                            cc = (cc + COLS) % COLS;
                        end
                        if ((dr != 0 || dc != 0) && rr >= 0 && rr < ROWS &&
                            cc >= 0 && cc < COLS && g[rr*COLS+cc])
                            n++;
                    end
                end
                o[r*COLS+c] = (n == 3) || (n == 2 && g[r*COLS+c]);
            end
        end
        return o;
    endfunction

    task automatic m_reset();
        m_grid = '0;
        m_gen = 0;
        m_run = 0;
        m_pend = 0;
        m_done = 0;
        m_stable = 0;
        m_extinct = 0;
    endtask

    task automatic m_flags_clear();
        m_done = 0;
        m_stable = 0;
        m_extinct = 0;
    endtask

    task automatic m_update();
        logic [N-1:0] nx;
        nx = life(m_grid, wrap);
        if (nx == m_grid) m_stable = 1;
        if (nx == '0) m_extinct = 1;
        if (max_gen != 0 && m_gen + 1 == int'(max_gen)) m_done = 1;
        m_grid = nx;
        if (m_gen < (1 << CNT_W) - 1) m_gen++;
    endtask

    task automatic model_edge();
        if (clear) begin
            m_reset();
        end else if (m_run) begin
            if (stop) begin
                m_run = 0;
            end else begin
                m_update();
                if (m_done || m_stable || m_extinct) m_run = 0;
            end
        end else if (m_pend) begin
            m_update();
            m_pend = 0;
        end else if (load) begin
            m_grid = seed;
            m_gen = 0;
            m_flags_clear();
        end else if (start) begin
            m_flags_clear();
            m_run = 1;
        end else if (step) begin
            m_flags_clear();
            m_pend = 1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".grid"}, grid, m_grid);
        check({tag, ".gen"}, gen_count, m_gen[CNT_W-1:0]);
        check({tag, ".running"}, running, m_run);
        check({tag, ".done"}, done, m_done);
        check({tag, ".stable"}, stable, m_stable);
        check({tag, ".extinct"}, extinct, m_extinct);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle_in();
        clear = 0;
        load = 0;
        start = 0;
        step = 0;
        stop = 0;
    endtask

    initial begin
        reset = 1;
        idle_in();
        seed = '0;
        wrap = 0;
        max_gen = '0;
        m_reset();

        vblink = '0;
        vblink = put(vblink, 7, 8);
        vblink = put(vblink, 8, 8);
        vblink = put(vblink, 9, 8);
        hblink = '0;
        hblink = put(hblink, 8, 7);
        hblink = put(hblink, 8, 8);
        hblink = put(hblink, 8, 9);
        block = '0;
        block = put(block, 4, 4);
        block = put(block, 4, 5);
        block = put(block, 5, 4);
        block = put(block, 5, 5);
        cell00 = put('0, 0, 0);
        glider = '0;
        glider = put(glider, 0, 1);
        glider = put(glider, 1, 2);
        glider = put(glider, 2, 0);
        glider = put(glider, 2, 1);
        glider = put(glider, 2, 2);

        #3;
        check_all("reset");
        #9 reset = 0;

        // Blinker single step, dead edges.
        seed = vblink;
        load = 1;
        tick("blink.load");
        load = 0;
        check("blink.loaded", grid, vblink);
        step = 1;
        tick("blink.step0");
        step = 0;
        tick("blink.step1");
        check("blink.hgrid", grid, hblink);
        check("blink.gen", gen_count, 1);
        check("blink.run", running, 0);
        check("blink.flags", {done, stable, extinct}, 0);

        // Still life halts the run on its first update.
        seed = block;
        load = 1;
        tick("block.load");
        load = 0;
        start = 1;
        tick("block.start");
        start = 0;
        check("block.running", running, 1);
        tick("block.upd");
        check("block.grid", grid, block);
        check("block.stable", stable, 1);
        check("block.gen", gen_count, 1);
        check("block.halt", running, 0);

        // Lone cell dies out.
        seed = cell00;
        load = 1;
        tick("ext.load");
        load = 0;
        step = 1;
        tick("ext.step0");
        step = 0;
        tick("ext.step1");
        check("ext.grid", grid, 0);
        check("ext.flag", extinct, 1);
        check("ext.gen", gen_count, 1);

        // Glider on a torus comes home after 64 generations.
        wrap = 1;
        max_gen = 16'd64;
        seed = glider;
        load = 1;
        tick("gl.load");
        load = 0;
        start = 1;
        tick("gl.start");
        start = 0;
        for (int k = 0; k < 100 && running; k++) tick("gl.run");
        check("gl.timeout", running, 0);
        check("gl.done", done, 1);
        check("gl.gen", gen_count, 64);
        check("gl.grid", grid, glider);
        check("gl.stable", stable, 0);

        // Stop on the 5th run edge, then resume.
        wrap = 0;
        max_gen = '0;
        seed = vblink;
        load = 1;
        tick("stop.load");
        load = 0;
        start = 1;
        tick("stop.start");
        start = 0;
        repeat (4) tick("stop.run");
        stop = 1;
        tick("stop.stop");
        stop = 0;
        check("stop.gen", gen_count, 4);
        check("stop.run", running, 0);
        start = 1;
        tick("stop.restart");
        start = 0;
        tick("stop.resume");
        check("stop.gen5", gen_count, 5);

        // Load during a run is ignored.
        blk2 = block;
        seed = blk2;
        load = 1;
        tick("ign.load");
        load = 0;
        check("ign.gen", gen_count, 6);
        check("ign.running", running, 1);

        // Clear beats load.
        clear = 1;
        load = 1;
        tick("clr.load");
        idle_in();
        check("clr.grid", grid, 0);
        check("clr.gen", gen_count, 0);

        // Async reset between edges.
        seed = vblink;
        load = 1;
        tick("ar.load");
        load = 0;
        start = 1;
        tick("ar.start");
        start = 0;
        tick("ar.run");
        #2 reset = 1;
        #1;
        m_reset();
        check("ar.grid", grid, 0);
        check("ar.gen", gen_count, 0);
        check("ar.run", running, 0);
        reset = 0;

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            idle_in();
            clear = ($urandom_range(0, 63) == 0);
            load  = ($urandom_range(0, 9) == 0);
            start = ($urandom_range(0, 5) == 0);
            step  = ($urandom_range(0, 5) == 0);
            stop  = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 7) == 0) wrap = 1'($urandom);
            if ($urandom_range(0, 15) == 0)
                max_gen = CNT_W'($urandom_range(0, 12));
            if (load) begin
                for (int w = 0; w < N / 32; w++)
                    seed[w*32 +: 32] = $urandom & $urandom;
            end
            tick("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
